stream_mux_rr: RTL and testbench

- Parametrised N-input, W-bit streaming multiplexer with valid/ready handshake on every input and on the output.
- Selection is either arbitrated (round-robin or fixed-priority) or forced by an explicit select input.
- The output is registered (one pipeline stage) so long mux trees close timing.
- Sits between multiple producer datapaths and one shared consumer, e.g. FSMD result buses feeding a common writeback port.

---
 rtl/stream_mux_pkg.sv | 12 +
 rtl/stream_mux_rr_if.sv | 41 ++++
 rtl/stream_mux_rr_arbiter.sv | 56 +++++
 rtl/stream_mux_rr.sv | 122 ++++++++++++
 tb/tb_stream_mux_rr.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the round-robin / fixed-priority stream mux.
package stream_mux_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // Channel-index width; a single channel still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: N producer channels in, one consumer out.
// Optional packet-lock signals exist only when STREAM_MUX_PKT_LOCK_EN is defined.
interface stream_mux_rr_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SEL_W = stream_mux_pkg::sel_width(N);

  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic             force_en;
  logic [SEL_W-1:0] force_sel;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;
  logic             out_valid;
  logic             out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [N-1:0]     in_last;
  logic             out_last;

  modport master (
    output in_data, in_valid, force_en, force_sel, out_ready, in_last,
    input  in_ready, out_data, out_sel, out_valid, out_last
  );
  modport slave (
    input  in_data, in_valid, force_en, force_sel, out_ready, in_last,
    output in_ready, out_data, out_sel, out_valid, out_last
  );
`else
  modport master (
    output in_data, in_valid, force_en, force_sel, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
  modport slave (
    input  in_data, in_valid, force_en, force_sel, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
`endif

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Request arbiter for stream_mux_rr: one-hot grant plus index, owns the
// round-robin pointer (MODE_RR) or gives lowest-index priority (MODE_FIXED).
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int  N     = 4,
  parameter int  MODE  = MODE_RR,
  localparam int SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic             advance_i,
  input  logic [SEL_W-1:0] adv_idx_i,
  output logic [N-1:0]     grant_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [SEL_W-1:0] ptr_q, ptr_d;

  // Scan all channels starting at the pointer (or at 0), first hit wins.
  always_comb begin
    int   c;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    c       = 0;
    for (int k = 0; k < N; k++) begin
      if (MODE == MODE_FIXED) begin
        c = k;
      end else begin
        c = int'(ptr_q) + k;
        if (c >= N) c = c - N;
      end
      if (!found && req_i[c]) begin
        found      = 1'b1;
        grant_o[c] = 1'b1;
        idx_o      = SEL_W'(c);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (MODE == MODE_RR && advance_i) begin
      ptr_d = (int'(adv_idx_i) >= N - 1) ? '0 : adv_idx_i + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-input valid/ready stream mux with registered output and forced-select override.
// Define STREAM_MUX_PKT_LOCK_EN to add in_last/out_last and hold the grant for a whole packet.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = MODE_RR
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_mux_rr_if.slave  bus
);

  localparam int SEL_W = sel_width(N);

  logic [N-1:0]     force_mask, elig, req, grant;
  logic [SEL_W-1:0] gidx;
  logic             load, xfer;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;

  // An out-of-range force_sel matches no channel, so nothing is eligible.
  always_comb begin
    force_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.force_sel == SEL_W'(i)) force_mask[i] = 1'b1;
    end
  end

  assign elig = bus.force_en ? (bus.in_valid & force_mask) : bus.in_valid;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_idx_q, lock_idx_d;
  logic             out_last_q, out_last_d;
  logic [N-1:0]     lock_mask;

  always_comb begin
    lock_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (lock_idx_q == SEL_W'(i)) lock_mask[i] = 1'b1;
    end
  end

  // A packet in flight pins the grant, ignoring arbitration and force.
  assign req = lock_q ? (bus.in_valid & lock_mask) : elig;
`else
  assign req = elig;
`endif

  rr_arbiter #(.N(N), .MODE(MODE)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .advance_i (xfer),
    .adv_idx_i (gidx),
    .grant_o   (grant),
    .idx_o     (gidx)
  );

  assign load         = ~out_valid_q | bus.out_ready;
  assign xfer         = load & (|grant);
  assign bus.in_ready = grant & {N{load}};

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load) out_valid_d = xfer;
    if (xfer) begin
      out_data_d = bus.in_data[int'(gidx)*W +: W];
      out_sel_d  = gidx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

`ifdef STREAM_MUX_PKT_LOCK_EN
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    out_last_d = out_last_q;
    if (xfer) begin
      lock_d     = ~bus.in_last[gidx];
      lock_idx_d = gidx;
      out_last_d = bus.in_last[gidx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      out_last_q <= out_last_d;
    end
  end

  assign bus.out_last = out_last_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: a 4-channel round-robin and a 5-channel
// fixed-priority instance share stimulus; a reference model predicts grants and beats.
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] vld = '0;
  logic [7:0] dat [5];
  logic       fe = 1'b0;
  logic [2:0] fs = '0;
  logic       ordy = 1'b0;
  logic [4:0] lst = '0;
  bit         keep_dat = 1'b0;
  bit         done = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Model state per instance (0: N=4 RR, 1: N=5 fixed)
  int         ptr [2];
  bit         mv  [2];
  bit         lk  [2];
  int         lidx[2];
  logic [11:0] exp_q [2][$];

  stream_mux_rr_if #(.N(4), .W(8)) b0 ();
  stream_mux_rr_if #(.N(5), .W(8)) b1 ();

  stream_mux_rr #(.N(4), .W(8), .MODE(MODE_RR))    dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  stream_mux_rr #(.N(5), .W(8), .MODE(MODE_FIXED)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  assign b0.in_valid  = vld[3:0];
  assign b1.in_valid  = vld;
  assign b0.in_data   = {dat[3], dat[2], dat[1], dat[0]};
  assign b1.in_data   = {dat[4], dat[3], dat[2], dat[1], dat[0]};
  assign b0.force_en  = fe;
  assign b1.force_en  = fe;
  assign b0.force_sel = fs[1:0];
  assign b1.force_sel = fs;
  assign b0.out_ready = ordy;
  assign b1.out_ready = ordy;
`ifdef STREAM_MUX_PKT_LOCK_EN
  assign b0.in_last = lst[3:0];
  assign b1.in_last = lst;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input int n, input int mode, input int p, input logic [4:0] e);
    for (int k = 0; k < n; k++) begin
      int c;
      c = (mode == MODE_FIXED) ? k : (p + k) % n;
      if (e[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_cycle();
    for (int d = 0; d < 2; d++) begin
      int n, s, g;
      bit load, lastb;
      logic [4:0] e, rdy_exp, rdy_act;
      n = (d == 0) ? 4 : 5;
      s = (d == 0) ? int'(fs[1:0]) : int'(fs);
      e = vld & ((d == 0) ? 5'h0f : 5'h1f);
      if (fe) e = (s < n) ? (e & (5'b1 << s)) : 5'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      if (lk[d]) e = vld & (5'b1 << lidx[d]);
`endif
      g = pick(n, d, ptr[d], e);
      load = !mv[d] || ordy;
      rdy_exp = (g >= 0 && load) ? (5'b1 << g) : 5'b0;
      rdy_act = (d == 0) ? 5'(b0.in_ready) : 5'(b1.in_ready);
      chk($sformatf("in_ready[dut%0d]", d), int'(rdy_act), int'(rdy_exp));
      chk($sformatf("out_valid[dut%0d]", d), (d == 0) ? int'(b0.out_valid) : int'(b1.out_valid), int'(mv[d]));
      if (g >= 0 && load) begin
        lastb = 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        lastb = lst[g];
        lk[d] = !lst[g];
        lidx[d] = g;
`endif
        exp_q[d].push_back({lastb, 3'(g), dat[g]});
        if (d == 0) ptr[d] = (g + 1) % n;
      end
      if (load) mv[d] = (g >= 0);
    end
  endtask

  task automatic cyc(input logic [4:0] v, input logic f, input logic [2:0] s,
                     input logic r, input logic [4:0] l);
    @(negedge clk);
    vld = v; fe = f; fs = s; ordy = r; lst = l;
    if (!keep_dat) for (int i = 0; i < 5; i++) dat[i] = 8'($urandom);
    #1;
    model_cycle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " out_valid0"}, int'(b0.out_valid), 0);
    chk({tag, " out_data0"},  int'(b0.out_data), 0);
    chk({tag, " out_sel0"},   int'(b0.out_sel), 0);
    chk({tag, " out_valid1"}, int'(b1.out_valid), 0);
    chk({tag, " out_data1"},  int'(b1.out_data), 0);
    chk({tag, " out_sel1"},   int'(b1.out_sel), 0);
`ifdef STREAM_MUX_PKT_LOCK_EN
    chk({tag, " out_last0"},  int'(b0.out_last), 0);
`endif
  endtask

  // Reset is asserted away from the clock edge so it must act asynchronously.
  task automatic do_reset();
    @(negedge clk);
    vld = 5'($urandom); ordy = 1'($urandom); fe = 1'($urandom); fs = 3'($urandom);
    rst_n = 1'b0;
    #1;
    chk_zero("reset");
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      mv[d] = 1'b0; ptr[d] = 0; lk[d] = 1'b0; lidx[d] = 0;
    end
    repeat (2) begin
      @(negedge clk);
      vld = 5'($urandom); ordy = 1'($urandom);
      for (int i = 0; i < 5; i++) dat[i] = 8'($urandom);
    end
    #1;
    chk_zero("reset-hold");
    vld = '0; fe = 1'b0;
    rst_n = 1'b1;
  endtask

  // Monitor: every accepted output beat must match the oldest predicted beat.
  initial begin
    while (!done) begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        for (int d = 0; d < 2; d++) begin
          logic [11:0] act, exp;
          bit hs;
          act = '0;
          if (d == 0) begin
            hs = b0.out_valid && ordy;
            act[10:0] = {1'b0, b0.out_sel, b0.out_data};
`ifdef STREAM_MUX_PKT_LOCK_EN
            act[11] = b0.out_last;
`endif
          end else begin
            hs = b1.out_valid && ordy;
            act[10:0] = {b1.out_sel, b1.out_data};
`ifdef STREAM_MUX_PKT_LOCK_EN
            act[11] = b1.out_last;
`endif
          end
          if (hs) begin
            if (exp_q[d].size() == 0) begin
              vectors++; miscompares++;
              $display("FAIL beat[dut%0d]: got unexpected beat 0x%0h, expected none", d, act);
            end else begin
              exp = exp_q[d].pop_front();
              chk($sformatf("beat{last,sel,data}[dut%0d]", d), int'(act), int'(exp));
            end
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 5; i++) dat[i] = '0;
    do_reset();

    // First beat after reset: channel 2 carrying A5
    keep_dat = 1'b1;
    dat[2] = 8'hA5;
    cyc(5'b00100, 1'b0, 3'd0, 1'b1, 5'b0);
    @(posedge clk); #1;
    chk("first out_data", int'(b0.out_data), 8'hA5);
    chk("first out_sel", int'(b0.out_sel), 2);
    chk("first out_valid", int'(b0.out_valid), 1);
    keep_dat = 1'b0;

    // Round-robin fairness from a fresh pointer
    do_reset();
    repeat (6) cyc(5'b01111, 1'b0, 3'd0, 1'b1, 5'b0);

    // Fixed priority: channel 1 beats channel 3 until it drops
    repeat (4) cyc(5'b01010, 1'b0, 3'd0, 1'b1, 5'b0);
    repeat (2) cyc(5'b01000, 1'b0, 3'd0, 1'b1, 5'b0);

    // Backpressure holds a 3C beat
    keep_dat = 1'b1;
    dat[0] = 8'h3C;
    cyc(5'b00001, 1'b0, 3'd0, 1'b1, 5'b0);
    repeat (3) cyc(5'b11111, 1'b0, 3'd0, 1'b0, 5'b0);
    chk("stall out_data", int'(b0.out_data), 8'h3C);
    keep_dat = 1'b0;
    repeat (2) cyc(5'b11111, 1'b0, 3'd0, 1'b1, 5'b0);

    // Forced select, then an index beyond the 5-channel instance
    repeat (3) cyc(5'b11111, 1'b1, 3'd3, 1'b1, 5'b0);
    repeat (2) cyc(5'b11111, 1'b1, 3'd5, 1'b1, 5'b0);
    chk("force out-of-range out_valid1", int'(b1.out_valid), 0);

`ifdef STREAM_MUX_PKT_LOCK_EN
    // Three-beat packet on channel 1 while channel 0 competes
    do_reset();
    cyc(5'b00011, 1'b1, 3'd1, 1'b1, 5'b00000);
    cyc(5'b00011, 1'b0, 3'd0, 1'b1, 5'b00000);
    cyc(5'b00011, 1'b0, 3'd0, 1'b1, 5'b00010);
    repeat (3) cyc(5'b00011, 1'b0, 3'd0, 1'b1, 5'b00011);
`endif

    // Random traffic with one mid-run reset
    for (int it = 0; it < 600; it++) begin
      if (it == 300) do_reset();
      cyc(5'($urandom), ($urandom_range(0, 7) == 0), 3'($urandom),
          ($urandom_range(0, 3) != 0), 5'($urandom));
    end

    repeat (4) cyc(5'b0, 1'b0, 3'd0, 1'b1, 5'b0);
    chk("drain queue dut0", exp_q[0].size(), 0);
    chk("drain queue dut1", exp_q[1].size(), 0);

    done = 1'b1;
    @(negedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
